// File: rtl/par_deserializer_pkg.sv
// Shared deserializer/serializer definitions: bit-order encodings and the
// count-width helper.
package deser_pkg;

  localparam bit ORD_MSB_FIRST = 1'b1;
  localparam bit ORD_LSB_FIRST = 1'b0;

  // Width needed to hold a bit count in 0..dw inclusive.
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/par_deserializer_if.sv
// Output word bus of the deserializer: word, bit count, valid and downstream ready.
interface par_deserializer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic [DATA_W-1:0] deser_data_o;
  logic              deser_data_val_o;
  logic [CNT_W-1:0]  deser_data_cnt_o;
  logic              deser_ready_i;

  modport master (
    output deser_data_o, deser_data_val_o, deser_data_cnt_o,
    input  deser_ready_i
  );

  modport slave (
    input  deser_data_o, deser_data_val_o, deser_data_cnt_o,
    output deser_ready_i
  );
endinterface

// File: rtl/par_deserializer_out_stage.sv
// Output hold register: keeps a word stable until ready, drops a new word
// arriving while blocked and flags it with a one-cycle overflow pulse.
module deser_out_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_val,
  output logic              o_overflow
);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      o_data     <= '0;
      o_cnt      <= '0;
      o_val      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      if (i_load) begin
        // A held word can be replaced only in the cycle it is consumed.
        if (!o_val || i_ready) begin
          o_data <= i_data;
          o_cnt  <= i_cnt;
          o_val  <= 1'b1;
        end else begin
          o_overflow <= 1'b1;
        end
      end else if (o_val && i_ready) begin
        o_val <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/par_deserializer.sv
// Serial-to-parallel deserializer with selectable bit order.
// Define PAR_DESER_FLUSH_EN to enable emitting partial words on flush_i.
module par_deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = ORD_MSB_FIRST
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic data_i,
  input  logic data_val_i,
  input  logic flush_i,
  par_deserializer_if.master bus,
  output logic overflow_o
);

  localparam int CNT_W = cnt_w(DATA_W);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [CNT_W-1:0]  w_pos;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_asm_nxt;
  logic              w_full;
  logic              w_flush;
  logic              w_load;

  assign w_pos = (MSB_FIRST == ORD_MSB_FIRST) ? (CNT_W'(DATA_W - 1) - r_cnt) : r_cnt;

  // Accept the incoming bit first so a same-cycle flush sees it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_asm_nxt = r_asm;
    if (data_val_i) begin
      w_asm_nxt = r_asm | ({{(DATA_W-1){1'b0}}, data_i} << w_pos);
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign w_full = (w_cnt_nxt == CNT_W'(DATA_W));

`ifdef PAR_DESER_FLUSH_EN
  assign w_flush = flush_i && (w_cnt_nxt != '0);
`else
  logic w_unused_flush;
  assign w_unused_flush = flush_i;
  assign w_flush        = 1'b0;
`endif

  assign w_load = w_full || w_flush;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_asm <= w_asm_nxt;
    end
  end

  deser_out_stage #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_out (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .i_load     (w_load),
    .i_data     (w_asm_nxt),
    .i_cnt      (w_cnt_nxt),
    .i_ready    (bus.deser_ready_i),
    .o_data     (bus.deser_data_o),
    .o_cnt      (bus.deser_data_cnt_o),
    .o_val      (bus.deser_data_val_o),
    .o_overflow (overflow_o)
  );

endmodule

// File: tb/tb_par_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one serial stream.
module tb_par_deserializer;

  logic clk_i = 1'b0;
  logic srst_i, data_i, data_val_i, flush_i, ready;
  logic ovf_m, ovf_l;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovf_pulses = 0;

  always #5 clk_i = ~clk_i;

  par_deserializer_if #(.DATA_W(16), .CNT_W(5)) bus_m ();
  par_deserializer_if #(.DATA_W(16), .CNT_W(5)) bus_l ();
  assign bus_m.deser_ready_i = ready;
  assign bus_l.deser_ready_i = ready;

  par_deserializer #(.DATA_W(16), .MSB_FIRST(1'b1)) u_m (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .flush_i(flush_i), .bus(bus_m), .overflow_o(ovf_m));

  par_deserializer #(.DATA_W(16), .MSB_FIRST(1'b0)) u_l (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .flush_i(flush_i), .bus(bus_l), .overflow_o(ovf_l));

  always @(negedge clk_i) if (ovf_m) ovf_pulses++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_i     = b;
    data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
  endtask

  // Bits go out MSB first; the final bit's edge has just passed on return.
  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    srst_i = 1'b1; data_i = 1'b0; data_val_i = 1'b0; flush_i = 1'b0; ready = 1'b1;
    tick(); tick();
    chk("rst_val", bus_m.deser_data_val_o, 1'b0);
    chk("rst_data", bus_m.deser_data_o, 16'h0);
    chk("rst_cnt", bus_m.deser_data_cnt_o, 5'd0);
    chk("rst_ovf", ovf_m, 1'b0);
    srst_i = 1'b0;

    // Full word, both bit orders
    send_word(16'hA5C3);
    chk("msb_val", bus_m.deser_data_val_o, 1'b1);
    chk("msb_data", bus_m.deser_data_o, 16'hA5C3);
    chk("msb_cnt", bus_m.deser_data_cnt_o, 5'd16);
    chk("lsb_val", bus_l.deser_data_val_o, 1'b1);
    chk("lsb_data", bus_l.deser_data_o, 16'hC3A5);
    chk("lsb_cnt", bus_l.deser_data_cnt_o, 5'd16);
    tick();
    chk("consumed", bus_m.deser_data_val_o, 1'b0);

    // Back-to-back words with ready high
    send_word(16'h1234);
    chk("b2b_w0", bus_m.deser_data_o, 16'h1234);
    send_bit(1'b1);
    chk("b2b_gap", bus_m.deser_data_val_o, 1'b0);
    for (int i = 14; i >= 0; i--) send_bit(1'b1);
    chk("b2b_w1_val", bus_m.deser_data_val_o, 1'b1);
    chk("b2b_w1", bus_m.deser_data_o, 16'hFFFF);
    chk("b2b_ovf", ovf_pulses, 0);
    tick();

    // Blocked downstream: second word dropped with one overflow pulse
    ready = 1'b0;
    send_word(16'h1234);
    chk("blk_val", bus_m.deser_data_val_o, 1'b1);
    send_word(16'hFFFF);
    chk("blk_ovf_hi", ovf_m, 1'b1);
    chk("blk_hold", bus_m.deser_data_o, 16'h1234);
    tick();
    chk("blk_ovf_lo", ovf_m, 1'b0);
    chk("blk_pulses", ovf_pulses, 1);
    chk("blk_still", bus_m.deser_data_val_o, 1'b1);
    ready = 1'b1;
    chk("rel_data", bus_m.deser_data_o, 16'h1234);
    tick();
    chk("rel_val", bus_m.deser_data_val_o, 1'b0);

    // Reset mid-word, asserted alongside data and ready
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    srst_i = 1'b1; data_val_i = 1'b1; data_i = 1'b1;
    tick();
    srst_i = 1'b0; data_val_i = 1'b0;
    chk("mid_rst_val", bus_m.deser_data_val_o, 1'b0);
    for (int i = 15; i >= 1; i--) send_bit(i < 8);
    chk("post_rst_partial", bus_m.deser_data_val_o, 1'b0);
    send_bit(1'b1);
    chk("post_rst_data", bus_m.deser_data_o, 16'h00FF);
    chk("post_rst_cnt", bus_m.deser_data_cnt_o, 5'd16);
    chk("post_rst_ovf", ovf_pulses, 1);
    tick();

`ifdef PAR_DESER_FLUSH_EN
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    flush_i = 1'b1;
    tick();
    chk("fl_val", bus_m.deser_data_val_o, 1'b1);
    chk("fl_data", bus_m.deser_data_o, 16'hB000);
    chk("fl_cnt", bus_m.deser_data_cnt_o, 5'd5);
    chk("fl_lsb_data", bus_l.deser_data_o, 16'h000D);
    tick();
    flush_i = 1'b0;
    chk("fl_empty", bus_m.deser_data_val_o, 1'b0);
    // Flush on the completing bit yields exactly one full word
    for (int i = 0; i < 15; i++) send_bit(1'b0);
    flush_i = 1'b1;
    send_bit(1'b1);
    flush_i = 1'b0;
    chk("fl_full_data", bus_m.deser_data_o, 16'h0001);
    chk("fl_full_cnt", bus_m.deser_data_cnt_o, 5'd16);
    tick();
    chk("fl_full_once", bus_m.deser_data_val_o, 1'b0);
`else
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("nofl_val", bus_m.deser_data_val_o, 1'b0);
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    chk("nofl_data", bus_m.deser_data_o, 16'hB000);
    chk("nofl_cnt", bus_m.deser_data_cnt_o, 5'd16);
    tick();
`endif

    chk("end_ovf", ovf_pulses, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/par_deserializer.md
PAR_DESERIALIZER -- requirements
Module: par_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the output word width; legal range 2..64.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in bit DATA_W-1; 0 = first received bit lands in bit 0.
REQ-003 The block SHALL have derived localparam CNT_W = $clog2(DATA_W+1).
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 srst_i  in  1  synchronous, active-high reset.
REQ-006 data_i  in  1  serial data bit.
REQ-007 data_val_i  in  1  data_i is valid and SHALL be accepted this cycle.
REQ-008 flush_i  in  1  request to emit the partially assembled word.
REQ-009 deser_ready_i  in  1  downstream accepts the output word.
REQ-010 deser_data_o  out  DATA_W  assembled word.
REQ-011 deser_data_val_o  out  1  deser_data_o and deser_data_cnt_o are valid.
REQ-012 deser_data_cnt_o  out  CNT_W  number of meaningful bits in deser_data_o (1..DATA_W).
REQ-013 overflow_o  out  1  one-cycle pulse: a completed word was dropped.

Function
REQ-014 Each cycle with data_val_i=1, the block SHALL store data_i at the next bit position per MSB_FIRST and increment the internal bit count.
REQ-015 The bit that brings the count to DATA_W SHALL complete a word; the count SHALL return to 0 in the same cycle, so back-to-back words need no idle cycle.
REQ-016 deser_data_val_o SHALL rise on the cycle after the completing bit is sampled (latency 1), with deser_data_cnt_o = DATA_W.
REQ-017 Once asserted, deser_data_val_o, deser_data_o and deser_data_cnt_o SHALL hold stable until a cycle where deser_ready_i=1; valid SHALL deassert after that cycle unless a new word is loaded in the same cycle.
REQ-018 A word completing while valid=1 and deser_ready_i=0 SHALL be dropped; overflow_o SHALL pulse for one cycle; the held word is unchanged.
REQ-019 A word completing while valid=1 and deser_ready_i=1 SHALL be loaded with no drop and no overflow.
REQ-020 Flush (REQ-027) with bit count k>0 SHALL produce an output word with the k received bits in the positions a full word would use and all other bits 0, cnt=k; flush with k=0 SHALL produce nothing.
REQ-021 flush_i and data_val_i in the same cycle: the bit SHALL be accepted first, then the flush applied; if that bit completes the word, exactly one full word SHALL be produced.
REQ-022 A flushed word SHALL obey the same hold/drop rules as REQ-017..REQ-019.
REQ-023 The assembly register SHALL clear to 0 on word completion or flush.

Reset
REQ-024 srst_i=1 SHALL clear bit count, assembly register, deser_data_o, deser_data_cnt_o, deser_data_val_o and overflow_o to 0 on the next edge.
REQ-025 Reset mid-word SHALL discard partial bits with no output and no overflow; reset dominates data_val_i, flush_i and deser_ready_i.
REQ-026 The first bit accepted after reset SHALL be word bit 0 of the sequence.

Configuration
REQ-027 With macro PAR_DESER_FLUSH_EN defined, flush_i SHALL operate per REQ-020..REQ-022; without it, flush_i SHALL be ignored, deser_data_cnt_o SHALL always equal DATA_W when valid, and no flush logic SHALL be synthesised; ports are identical in both builds.

Structure
REQ-028 Package deser_pkg SHALL hold the bit-order encoding constants (MSB_FIRST/LSB_FIRST) and the CNT_W width function, shared with the serializer.
REQ-029 The output hold/handshake register SHALL be a sub-module deser_out_stage (data, cnt, valid, ready, overflow); bit collection stays in par_deserializer.

Verification
REQ-030 DATA_W=16, MSB_FIRST=1, ready=1, bits of 0xA5C3 MSB first on 16 consecutive cycles -> one cycle later valid=1, data=0xA5C3, cnt=16.
REQ-031 MSB_FIRST=0, same bit stream -> data=0xC3A5 bit-reversed equivalent (0xC3A5 reversed = 0xA5C3 read LSB-first), cnt=16; 32 back-to-back bits -> two consecutive valid cycles.
REQ-032 ready=0, two full words 0x1234, 0xFFFF streamed -> output holds 0x1234; overflow_o pulses once one cycle after the 32nd bit; ready=1 then releases 0x1234.
REQ-033 PAR_DESER_FLUSH_EN, MSB_FIRST=1, 5 bits 1,0,1,1,0 then flush_i -> data=0xB000, cnt=5; immediate second flush -> no output.
REQ-034 10 bits then srst_i, then 16 bits of 0x00FF -> single output 0x00FF, cnt=16, no partial word, overflow_o never set.
